btb_predictor: RTL

- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Supplies `predict` / `predict_pc` to the fetch stage in the same cycle as the fetch PC.
- Trained by resolved branch/jump outcomes from EX.
- Indexed on halfword granularity so compressed (16-bit) instructions at pc[1]=1 get their own entries.

---
 rtl/btb_predictor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Lookup is combinational on the fetch PC. Training comes from
//   resolved control transfers in EX and is registered on the clock edge.
//   Entries are indexed on halfword granularity so that compressed
//   instructions at pc[1]=1 get their own entries.
//
//   Optional feature: define BTB_STATS_EN to add the update and mispredict
//   statistics counters (stat_updates, stat_mispredicts).
//
// Ports
//   clk              clock
//   rstn             synchronous active-low reset (clears valid bits only)
//   pc               fetch PC to look up
//   predict          predicted taken for pc (combinational)
//   predict_pc       predicted target, 0 when predict=0 (combinational)
//   upd_valid        EX resolved a control-transfer instruction this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual direction
//   upd_target       actual target (used when upd_taken=1)
//   upd_mispredict   EX detected a misprediction (statistics only)
//   stat_updates     accepted update count        (BTB_STATS_EN only)
//   stat_mispredicts mispredicted update count    (BTB_STATS_EN only)
// ---------------------------------------------------------------------------
module btb_predictor #(
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  output logic        predict,
  output logic [31:0] predict_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 31 - IDX_W;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Only the valid bits are reset; tag/target/counter storage is don't-care
  // until an entry is allocated.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  // Lookup: pc[0] never participates; the tag covers pc[31:IDX_W+1].
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;

  assign l_idx      = pc[IDX_W:1];
  assign l_tag      = pc[31:IDX_W+1];
  assign l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign predict    = l_hit && cnt_q[l_idx][1];
  assign predict_pc = predict ? tgt_q[l_idx] : 32'h0;

  // Update side
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             alloc;
  logic             train;
  logic [1:0]       cnt_upd_d;

  assign u_idx = upd_pc[IDX_W:1];
  assign u_tag = upd_pc[31:IDX_W+1];
  assign u_hit = valid_q[u_idx] && (u_tag == tag_q[u_idx]);
  // A not-taken miss leaves the table untouched: no point caching a branch
  // that would only ever predict fall-through.
  assign alloc = upd_valid && !u_hit && upd_taken;
  assign train = upd_valid && u_hit;

  always_comb begin
    cnt_upd_d = cnt_q[u_idx];
    if (train) begin
      cnt_upd_d = upd_taken ? sat_inc(cnt_q[u_idx]) : sat_dec(cnt_q[u_idx]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (alloc) begin
      valid_d[u_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Storage writes are suppressed during reset so a concurrent update leaves
  // no trace. Lookup in the same cycle sees the old contents (no bypass).
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (alloc) begin
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= upd_target;
        cnt_q[u_idx] <= CNT_INIT;
      end else if (train) begin
        cnt_q[u_idx] <= cnt_upd_d;
        if (upd_taken) begin
          tgt_q[u_idx] <= upd_target;
        end
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_mis_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (upd_valid) begin
        stat_upd_q <= stat_upd_q + 32'd1;
      end
      if (upd_valid && upd_mispredict) begin
        stat_mis_q <= stat_mis_q + 32'd1;
      end
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;

  logic [1:0] unused_bits;
  assign unused_bits = {pc[0], upd_pc[0]};
`else
  logic [2:0] unused_bits;
  assign unused_bits = {pc[0], upd_pc[0], upd_mispredict};
`endif

endmodule
